// File: rtl/student_pipe_addsub.sv
// student_pipe_addsub: pipelined two's-complement adder/subtractor, one carry-rippled chunk per stage
// with valid/ready flow control; student_full_adder is the per-bit cell.
module student_full_adder (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic c_o
);
  assign s_o = a_i ^ b_i ^ c_i;
  assign c_o = (a_i & b_i) | (c_i & (a_i ^ b_i));
endmodule

module student_pipe_addsub #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             carry_out,
  output logic             overflow
);
  localparam int C = WIDTH / STAGES;
  logic adv;
  logic ovf_q;
  assign adv      = !out_valid | out_ready;
  assign in_ready = adv;
  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int XW = WIDTH - k * C;
    // w rotates right by one chunk per stage: unsummed a chunk at the bottom, finished sums enter at the top
    logic [WIDTH-1:0] w_x, w_d, w_q;
    logic [XW-1:0]    b_x;
    logic             s_x, v_x, ci;
    logic [C:0]       cc;
    logic [C-1:0]     sm;
    logic             v_q, c_q;
    if (k == 0) begin : g_in
      assign w_x = a;
      assign b_x = b;
      assign s_x = sub;
      assign v_x = in_valid;
      assign ci  = sub;
    end else begin : g_link
      assign w_x = g_stage[k-1].w_q;
      assign b_x = g_stage[k-1].g_fwd.b_q;
      assign s_x = g_stage[k-1].g_fwd.s_q;
      assign v_x = g_stage[k-1].v_q;
      assign ci  = g_stage[k-1].c_q;
    end
    assign cc[0] = ci;
    for (genvar j = 0; j < C; j++) begin : g_fa
      student_full_adder u_fa (
        .a_i(w_x[j]),
        .b_i(b_x[j] ^ s_x),
        .c_i(cc[j]),
        .s_o(sm[j]),
        .c_o(cc[j+1])
      );
    end
    if (STAGES == 1) begin : g_one
      assign w_d = sm;
    end else begin : g_rot
      assign w_d = {sm, w_x[WIDTH-1:C]};
    end
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
        v_q <= 1'b0;
        w_q <= '0;
        c_q <= 1'b0;
      end else if (adv) begin
        v_q <= v_x;
        w_q <= w_d;
        c_q <= cc[C];
      end
    if (k < STAGES - 1) begin : g_fwd
      logic [XW-C-1:0] b_q;
      logic            s_q;
      always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
          b_q <= '0;
          s_q <= 1'b0;
        end else if (adv) begin
          b_q <= b_x[XW-1:C];
          s_q <= s_x;
        end
    end else begin : g_last
      always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) ovf_q <= 1'b0;
        else if (adv) ovf_q <= cc[C-1] ^ cc[C];
    end
  end
  assign out       = g_stage[STAGES-1].w_q;
  assign out_valid = g_stage[STAGES-1].v_q;
  assign carry_out = g_stage[STAGES-1].c_q;
  assign overflow  = ovf_q;
endmodule

// File: tb/tb_student_pipe_addsub.sv
// tb_student_pipe_addsub: directed and random checks of the 4-, 1- and 16-stage adder/subtractor
module tb_student_pipe_addsub;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  logic        in_valid = 1'b0, sub_i = 1'b0, out_ready = 1'b1;
  logic [15:0] a_i = '0, b_i = '0;
  logic [2:0]  rdy, vld, co, ov;
  logic [15:0] res [3];
  student_pipe_addsub #(.WIDTH(16), .STAGES(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy[0]), .a(a_i), .b(b_i), .sub(sub_i),
    .out_valid(vld[0]), .out_ready(out_ready), .out(res[0]), .carry_out(co[0]), .overflow(ov[0]));
  student_pipe_addsub #(.WIDTH(16), .STAGES(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy[1]), .a(a_i), .b(b_i), .sub(sub_i),
    .out_valid(vld[1]), .out_ready(out_ready), .out(res[1]), .carry_out(co[1]), .overflow(ov[1]));
  student_pipe_addsub #(.WIDTH(16), .STAGES(16)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy[2]), .a(a_i), .b(b_i), .sub(sub_i),
    .out_valid(vld[2]), .out_ready(out_ready), .out(res[2]), .carry_out(co[2]), .overflow(ov[2]));

  typedef struct packed {logic [15:0] r; logic c; logic v; int t;} exp_t;
  int          errors = 0, checks = 0, cyc = 0;
  logic        lat_chk = 1'b1, hand = 1'b0;
  logic [15:0] h_r = '0;
  logic        h_c = 1'b0, h_v = 1'b0;
  exp_t        fifo [3][64];
  int          wr [3], rd [3];
  int          lat [3] = '{4, 1, 16};
  logic        held [3];
  logic [17:0] hold_val [3];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [15:0] x, input logic [15:0] y, input logic s, input int t);
    exp_t        e;
    logic [16:0] full;
    full = {1'b0, x} + {1'b0, s ? ~y : y} + {16'd0, s};
    e.r  = full[15:0];
    e.c  = full[16];
    e.v  = s ? (x[15] != y[15] && full[15] != x[15]) : (x[15] == y[15] && full[15] != x[15]);
    e.t  = t;
    return e;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    cyc++;
    for (int d = 0; d < 3; d++) begin
      if (!rst_n) begin
        rd[d]   = wr[d];
        held[d] = 1'b0;
      end else begin
        if (vld[d] && !out_ready) begin
          if (held[d]) chk($sformatf("stall_hold_d%0d", d), {co[d], ov[d], res[d]}, hold_val[d]);
          held[d]     = 1'b1;
          hold_val[d] = {co[d], ov[d], res[d]};
        end else held[d] = 1'b0;
        if (vld[d] && out_ready) begin
          if (rd[d] == wr[d]) chk($sformatf("spurious_out_d%0d", d), vld[d], 1'b0);
          else begin
            e = fifo[d][rd[d] % 64];
            rd[d]++;
            chk($sformatf("out_d%0d", d), res[d], e.r);
            chk($sformatf("carry_d%0d", d), co[d], e.c);
            chk($sformatf("ovf_d%0d", d), ov[d], e.v);
            if (lat_chk) chk($sformatf("latency_d%0d", d), cyc - e.t, lat[d]);
          end
        end
        if (in_valid && rdy[d]) begin
          fifo[d][wr[d] % 64] = hand ? exp_t'{h_r, h_c, h_v, cyc} : model(a_i, b_i, sub_i, cyc);
          wr[d]++;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] x, input logic [15:0] y, input logic s,
                      input logic hd, input logic [15:0] hr, input logic hc, input logic hv);
    int n = 0;
    a_i = x; b_i = y; sub_i = s; hand = hd; h_r = hr; h_c = hc; h_v = hv; in_valid = 1'b1;
    @(negedge clk);
    while (!rdy[0] && n < 50) begin
      tick();
      @(negedge clk);
      n++;
    end
    if (n == 50) chk("send_timeout", n, 0);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (n < 100 && (rd[0] != wr[0] || rd[1] != wr[1] || rd[2] != wr[2])) begin
      tick();
      n++;
    end
    chk("drain_done", n < 100, 1'b1);
  endtask

  logic [15:0] va [8] = '{16'h0001, 16'h8000, 16'hFFFF, 16'h1234, 16'h7FFF, 16'hAAAA, 16'h0F0F, 16'hC000};
  logic [15:0] vb [8] = '{16'hFFFF, 16'h8000, 16'h0001, 16'h4321, 16'h8000, 16'h5555, 16'hF0F0, 16'h4000};

  initial begin
    #12;
    chk("reset_valid", vld, 3'b000);
    chk("reset_out", res[0], 16'h0000);
    chk("reset_carry", co, 3'b000);
    chk("reset_ovf", ov, 3'b000);
    rst_n = 1'b1;
    tick();
    chk("ready_after_reset", rdy, 3'b111);
    send(16'h1234, 16'h0FFF, 1'b0, 1'b1, 16'h2233, 1'b0, 1'b0);
    drain();
    send(16'hFFFF, 16'h0001, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0);
    send(16'h7FFF, 16'h0001, 1'b0, 1'b1, 16'h8000, 1'b0, 1'b1);
    send(16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    send(16'h8000, 16'h0001, 1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b1);
    send(16'h0007, 16'h0005, 1'b1, 1'b1, 16'h0002, 1'b1, 1'b0);
    send(16'h0000, 16'h0000, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b0);
    drain();
    lat_chk = 1'b0;
    fork
      for (int i = 0; i < 8; i++) send(va[i], vb[i], i[0], 1'b0, 16'h0, 1'b0, 1'b0);
      begin
        repeat (6) tick();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
          @(negedge clk);
          chk("stall_in_ready", rdy[0], 1'b0);
          chk("stall_out_valid", vld[0], 1'b1);
          tick();
        end
        out_ready = 1'b1;
      end
    join
    drain();
    lat_chk = 1'b1;
    for (int i = 0; i < 3; i++) send(16'h1111 * 16'(i + 1), 16'h0101, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("flush_valid", vld, 3'b000);
    chk("flush_out", res[0], 16'h0000);
    tick();
    tick();
    rst_n = 1'b1;
    repeat (20) tick();
    chk("nothing_emitted", vld, 3'b000);
    send(16'hABCD, 16'h1111, 1'b0, 1'b1, 16'hBCDE, 1'b0, 1'b0);
    drain();
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) tick();
      send(16'($urandom), 16'($urandom), 1'($urandom), 1'b0, 16'h0, 1'b0, 1'b0);
    end
    drain();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
